addr_sequencer: RTL and testbench
=================================

ADDR_SEQUENCER -- requirements
Module: addr_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 85: number of address steps per pass, equal to the bank depth of the address generator.
REQ-002 SHALL have parameter READ_LAT, default 2: memory read latency in cycles, drained before done; legal range 0..7.
REQ-003 SHALL have parameter CW, default 7: step counter width; DEPTH <= 2^CW.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a pass; honoured only in IDLE.
REQ-007 mode_in  input  1  pass type, sampled with start: 0 = linear pass, 1 = shifted (transpose) pass.
REQ-008 abort  input  1  synchronous cancel of the current pass.
REQ-009 out_ready  input  1  downstream can accept the current address vector.
REQ-010 ag_reset  output  1  active-high initialisation strobe to the address generator.
REQ-011 ag_mode  output  1  mode to the address generator; holds the latched mode_in.
REQ-012 ag_incr  output  1  advance strobe to the address generator.
REQ-013 out_valid  output  1  the generator's address vector is valid this cycle.
REQ-014 out_last  output  1  qualifies the final step of the pass.
REQ-015 step  output  CW  index of the current step, 0..DEPTH-1.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement the states IDLE, INIT, RUN, DRAIN and DONE, encoded in registers.
REQ-019 IDLE->INIT when start=1: mode_in latched into ag_mode; step cleared to 0.
REQ-020 INIT SHALL last exactly 1 cycle with ag_reset=1, then go to RUN.
REQ-021 In RUN: out_valid=1; out_last=(step==DEPTH-1); ag_incr=out_valid&out_ready (combinational).
REQ-022 In RUN, on a transfer (out_valid&out_ready) with step<DEPTH-1: step increments by 1.
REQ-023 In RUN, on a transfer with step==DEPTH-1: go to DRAIN; step holds at DEPTH-1 (no wrap).
REQ-024 In RUN with out_ready=0: hold state, step and outputs; ag_incr=0 (stall).
REQ-025 DRAIN SHALL last READ_LAT cycles via an internal down-counter; with READ_LAT=0, go directly to DONE.
REQ-026 DONE SHALL last exactly 1 cycle with done=1, then go to IDLE.
REQ-027 ag_incr, ag_reset and out_valid SHALL be 0 in every state other than those defined above for them.
REQ-028 abort=1 in any non-IDLE state: go to IDLE next cycle; no done pulse; ag_incr forced to 0 that cycle.
REQ-029 abort=1 SHALL take priority over a simultaneous transfer.
REQ-030 start while busy=1 SHALL be ignored; it is not queued.
REQ-031 start and abort together in IDLE: start wins; abort has no effect in IDLE.
REQ-032 ag_mode SHALL be stable from INIT until the next accepted start.
REQ-033 Total pass latency without stalls (start -> done): 1 + 1 + DEPTH + READ_LAT + 1 cycles.

Reset
REQ-034 Reset asserted (low) SHALL take effect immediately, independent of clk, mid-pass included.
REQ-035 Reset values: state=IDLE; step=0; ag_mode=0; drain counter=0; all 1-bit outputs 0.
REQ-036 After reset release, the first start SHALL be honoured on the first rising edge.

Verification
REQ-037 Scenario: start with mode_in=0, out_ready=1 -> INIT 1 cycle, then 85 consecutive ag_incr, out_last on step 84, 2 DRAIN cycles, done at cycle 89 after start.
REQ-038 Scenario: mode_in=1, out_ready low on steps 10 and 40 -> step holds and ag_incr=0 during stalls, ag_mode=1 throughout, exactly 85 transfers, done 2 cycles later than unstalled.
REQ-039 Scenario: abort at step 30 -> busy=0 next cycle, no done pulse, ag_incr=0 in the abort cycle; a following start runs a full 85-step pass.
REQ-040 Scenario: reset pulled low at step 50 -> all outputs 0 asynchronously, state IDLE, step=0.
REQ-041 Scenario: start pulsed during RUN and in the DONE cycle -> ignored, only one pass completes.
REQ-042 Scenario: READ_LAT=0, DEPTH=4 -> done on the cycle after the transfer with step=3; start and abort together in IDLE -> pass starts.

Source files
------------

// File: rtl/addr_sequencer.sv
// Address sequencer: steps an external address generator through one pass of
// DEPTH addresses. It handles backpressure, drains the memory read latency and
// then pulses done. A pass can be aborted or reset at any point.
module addr_sequencer #(
  parameter int DEPTH    = 85,
  parameter int READ_LAT = 2,
  parameter int CW       = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode_in,
  input  logic          abort,
  input  logic          out_ready,
  output logic          ag_reset,
  output logic          ag_mode,
  output logic          ag_incr,
  output logic          out_valid,
  output logic          out_last,
  output logic [CW-1:0] step,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CW-1:0] LAST_STEP  = CW'(DEPTH - 1);
  // The drain counter counts down to zero, so it is loaded with one less than
  // the number of drain cycles wanted.
  localparam logic [2:0]    DRAIN_LOAD = (READ_LAT > 0) ? 3'(READ_LAT - 1) : 3'd0;

  state_t        state_q, state_d;
  logic [CW-1:0] step_d;
  logic          mode_d;
  logic [2:0]    drain_q, drain_d;

  // State, step index, latched mode and drain counter; async active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      step    <= '0;
      ag_mode <= 1'b0;
      drain_q <= 3'd0;
    end else begin
      state_q <= state_d;
      step    <= step_d;
      ag_mode <= mode_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic and all strobes; abort overrides everything outside IDLE
  always_comb begin
    state_d   = state_q;
    step_d    = step;
    mode_d    = ag_mode;
    drain_d   = drain_q;
    ag_reset  = 1'b0;
    ag_incr   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          mode_d  = mode_in;
          step_d  = '0;
        end
      end

      S_INIT: begin
        ag_reset = 1'b1;
        state_d  = S_RUN;
      end

      S_RUN: begin
        out_valid = 1'b1;
        out_last  = (step == LAST_STEP);
        // A transfer is lost if abort arrives in the same cycle.
        if (out_ready && !abort) begin
          ag_incr = 1'b1;
          if (step == LAST_STEP) begin
            state_d = (READ_LAT == 0) ? S_DONE : S_DRAIN;
            drain_d = DRAIN_LOAD;
          end else begin
            step_d = step + CW'(1);
          end
        end
      end

      S_DRAIN: begin
        if (drain_q == 3'd0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end

      S_DONE: begin
        done    = !abort;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      drain_d = 3'd0;
    end
  end

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed bench for addr_sequencer: default instance (DEPTH=85, READ_LAT=2)
// plus a small instance (DEPTH=4, READ_LAT=0).
module tb_addr_sequencer;

  logic       clk;
  logic       reset;
  logic       start, mode_in, abort, out_ready;
  logic       ag_reset, ag_mode, ag_incr, out_valid, out_last, busy, done;
  logic [6:0] step;

  logic       s_start, s_mode_in, s_abort, s_out_ready;
  logic       s_ag_reset, s_ag_mode, s_ag_incr, s_out_valid, s_out_last, s_busy, s_done;
  logic [2:0] s_step;

  int n_vec = 0;
  int n_err = 0;

  addr_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in), .abort(abort),
    .out_ready(out_ready), .ag_reset(ag_reset), .ag_mode(ag_mode), .ag_incr(ag_incr),
    .out_valid(out_valid), .out_last(out_last), .step(step), .busy(busy), .done(done)
  );

  addr_sequencer #(.DEPTH(4), .READ_LAT(0), .CW(3)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .mode_in(s_mode_in), .abort(s_abort),
    .out_ready(s_out_ready), .ag_reset(s_ag_reset), .ag_mode(s_ag_mode),
    .ag_incr(s_ag_incr), .out_valid(s_out_valid), .out_last(s_out_last),
    .step(s_step), .busy(s_busy), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Runs one pass on the default instance starting from IDLE. Cycle 0 is the
  // start cycle; the task returns in the cycle where done is seen (or times out).
  task automatic run_pass(input logic mode, input bit stall, input bit poke,
                          output int n_incr, output int done_at, output int rst_at,
                          output int last_step, output int n_last,
                          output int mode_bad, output int stall_bad);
    bit s10, s40, pend;
    int held;
    n_incr = 0; done_at = -1; rst_at = -1; last_step = -1; n_last = 0;
    mode_bad = 0; stall_bad = 0; s10 = 0; s40 = 0; pend = 0; held = 0;
    start = 1'b1; mode_in = mode; out_ready = 1'b1; abort = 1'b0;
    #1;
    for (int c = 1; c < 300; c++) begin
      cyc();
      start = poke && (c == 20 || c == 89);
      mode_in = ~mode;
      if (pend) begin
        if (step != 7'(held)) stall_bad++;
        pend = 0;
      end
      out_ready = 1'b1;
      if (stall && out_valid && step == 7'd10 && !s10) begin
        out_ready = 1'b0; s10 = 1; pend = 1; held = 10;
      end else if (stall && out_valid && step == 7'd40 && !s40) begin
        out_ready = 1'b0; s40 = 1; pend = 1; held = 40;
      end
      #1;
      if (ag_incr) n_incr++;
      if (!out_ready && ag_incr) stall_bad++;
      if (ag_reset) rst_at = c;
      if (out_last) begin
        last_step = int'(step);
        n_last++;
      end
      if (busy && ag_mode != mode) mode_bad++;
      if (done) begin
        done_at = c;
        break;
      end
    end
  endtask

  int n_incr, done_at, rst_at, last_step, n_last, mode_bad, stall_bad, seen;

  initial begin
    reset = 1'b0;
    start = 1'b0; mode_in = 1'b0; abort = 1'b0; out_ready = 1'b0;
    s_start = 1'b0; s_mode_in = 1'b0; s_abort = 1'b0; s_out_ready = 1'b0;
    cyc();
    cyc();
    #1;
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_step", step, 0);
    chk_eq("rst_ag_mode", ag_mode, 0);
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_ag_reset", ag_reset, 0);
    reset = 1'b1;

    // Linear pass without stalls
    run_pass(1'b0, 0, 0, n_incr, done_at, rst_at, last_step, n_last, mode_bad, stall_bad);
    chk_eq("lin_incr", n_incr, 85);
    chk_eq("lin_done_at", done_at, 89);
    chk_eq("lin_init_cycle", rst_at, 1);
    chk_eq("lin_last_step", last_step, 84);
    chk_eq("lin_last_cnt", n_last, 1);
    chk_eq("lin_mode", mode_bad, 0);
    cyc(); start = 1'b0; #1;
    chk_eq("lin_done_1cyc", done, 0);
    chk_eq("lin_idle", busy, 0);

    // Transpose pass with two single-cycle stalls
    run_pass(1'b1, 1, 0, n_incr, done_at, rst_at, last_step, n_last, mode_bad, stall_bad);
    chk_eq("stl_incr", n_incr, 85);
    chk_eq("stl_done_at", done_at, 91);
    chk_eq("stl_hold", stall_bad, 0);
    chk_eq("stl_mode", mode_bad, 0);
    cyc(); start = 1'b0; #1;
    chk_eq("stl_ag_mode_kept", ag_mode, 1);

    // Abort at step 30
    start = 1'b1; mode_in = 1'b0; out_ready = 1'b1; #1;
    for (int i = 0; i < 200; i++) begin
      cyc(); start = 1'b0;
      if (out_valid && step == 7'd30) break;
    end
    chk_eq("abt_reach", step, 30);
    abort = 1'b1; #1;
    chk_eq("abt_incr", ag_incr, 0);
    cyc(); abort = 1'b0; #1;
    chk_eq("abt_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(); #1;
      if (done || busy) seen++;
    end
    chk_eq("abt_no_done", seen, 0);
    run_pass(1'b0, 0, 0, n_incr, done_at, rst_at, last_step, n_last, mode_bad, stall_bad);
    chk_eq("abt_next_incr", n_incr, 85);
    chk_eq("abt_next_done", done_at, 89);
    cyc(); start = 1'b0; #1;

    // Asynchronous reset at step 50 with mode 1 latched
    start = 1'b1; mode_in = 1'b1; out_ready = 1'b1; #1;
    for (int i = 0; i < 200; i++) begin
      cyc(); start = 1'b0;
      if (out_valid && step == 7'd50) break;
    end
    chk_eq("ar_reach", step, 50);
    reset = 1'b0; #1;
    chk_eq("ar_busy", busy, 0);
    chk_eq("ar_step", step, 0);
    chk_eq("ar_ag_mode", ag_mode, 0);
    chk_eq("ar_out_valid", out_valid, 0);
    chk_eq("ar_ag_incr", ag_incr, 0);
    chk_eq("ar_out_last", out_last, 0);
    cyc();
    reset = 1'b1;
    run_pass(1'b0, 0, 0, n_incr, done_at, rst_at, last_step, n_last, mode_bad, stall_bad);
    chk_eq("ar_first_start_done", done_at, 89);
    cyc(); start = 1'b0; #1;

    // Start pulses during RUN and during DONE are ignored
    run_pass(1'b0, 0, 1, n_incr, done_at, rst_at, last_step, n_last, mode_bad, stall_bad);
    chk_eq("ign_incr", n_incr, 85);
    chk_eq("ign_done_at", done_at, 89);
    seen = 0;
    cyc(); start = 1'b0; #1;
    if (busy) seen++;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      if (busy || done) seen++;
    end
    chk_eq("ign_no_second", seen, 0);

    // Small instance, READ_LAT=0; start and abort together in IDLE
    s_start = 1'b1; s_abort = 1'b1; s_out_ready = 1'b1; #1;
    n_incr = 0; done_at = -1; last_step = -1;
    for (int c = 1; c < 30; c++) begin
      cyc(); s_start = 1'b0; s_abort = 1'b0; #1;
      if (s_ag_incr) n_incr++;
      if (s_ag_incr && s_step == 3'd3) last_step = c;
      if (s_done) begin
        done_at = c;
        break;
      end
    end
    chk_eq("sm_incr", n_incr, 4);
    chk_eq("sm_last_xfer", last_step, 5);
    chk_eq("sm_done_at", done_at, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
